search_time_manager: RTL and testbench
======================================

// Module: search_time_manager
// PURPOSE
//  Turns UCI clock info (remaining time, increment, optional fixed movetime) into a per-move search budget.
//  Counts that budget down in clock cycles.
//  Sits between uci_handler (go/time/inc) and engine_coordinator (consumes time_out as its time_in).
//  Tracks elapsed search time in ms for info output. Flags expiry until a best move is reported.
// PARAMETERS
//  CLOCK_FREQ     40_000_000  clk_in frequency in Hz; CYC_PER_MS = CLOCK_FREQ/1000 (must be >= 2)
//  TIME_SHIFT     3           budget fraction of remaining time: time_ms_in >> TIME_SHIFT
//  MIN_BUDGET_MS  1           floor on computed budget (ms)
// PORTS
//  clk_in          in   1   single clock domain
//  rst_in          in   1   synchronous, active-low reset
//  go_in           in   1   1-cycle pulse: start a search budget
//  time_ms_in      in   32  our remaining clock (ms); sampled on go_in
//  inc_ms_in       in   32  our increment (ms); sampled on go_in
//  fixed_en_in     in   1   1 = use fixed_ms_in as budget (movetime/override); sampled on go_in
//  fixed_ms_in     in   32  fixed budget (ms); sampled on go_in
//  abort_in        in   1   1-cycle pulse: UCI stop; force expiry
//  move_valid_in   in   1   engine reported bestmove; ends search
//  time_out        out  32  cycles remaining in budget; reset 0
//  running_out     out  1   1 in CALC/RUN; reset 0
//  expired_out     out  1   1-cycle pulse on budget exhaustion or abort; reset 0
//  elapsed_ms_out  out  32  ms elapsed since go; saturates at 32'hFFFF_FFFF; reset 0
// BEHAVIOUR
//  States: IDLE, CALC, RUN, EXPIRED; reset -> IDLE, all outputs 0, prescaler 0.
//  IDLE: go_in -> CALC.
//   Latch budget_ms = fixed_en_in ? fixed_ms_in : min(inc_ms_in, time_ms_in>>TIME_SHIFT).
//   Clamp: budget_ms = max(budget_ms, MIN_BUDGET_MS).
//   Clear elapsed_ms_out and prescaler.
//  CALC (1 cycle): product = budget_ms * CYC_PER_MS in 64 bits.
//   Saturate to 32'hFFFF_FFFF if upper bits nonzero; load time_out.
//   Move to RUN. time_out is valid 2 cycles after go_in.
//  RUN: time_out decrements by 1 each cycle.
//   time_out==1 with no other event -> time_out=0, expired_out pulse, -> EXPIRED.
//  EXPIRED: time_out held 0; stays until move_valid_in -> IDLE. expired_out never re-pulses.
//  abort_in in CALC/RUN: next cycle time_out=0, expired_out pulse, -> EXPIRED.
//  move_valid_in in CALC/RUN/EXPIRED: -> IDLE.
//   time_out=0 next cycle; elapsed_ms_out frozen (held until next go); no expired_out pulse.
//  Priority, same cycle: go_in > move_valid_in > abort_in > natural expiry.
//   go_in in any non-IDLE state restarts: latch, -> CALC, elapsed cleared.
//   move_valid_in and last RUN cycle together: IDLE, no pulse.
//  Elapsed counter: prescaler 0..CYC_PER_MS-1 runs only in CALC/RUN/EXPIRED.
//   On wrap, elapsed_ms_out += 1, saturating.
//  running_out = (state==CALC || state==RUN), registered with the state.
//  Inputs are sampled only on go_in; changes at other times have no effect.
//  rst_in low mid-search: next edge -> IDLE, all outputs 0; no expired_out pulse.
// STRUCTURE
//  chess_pkg additions: typedef enum logic [1:0] {TM_IDLE, TM_CALC, TM_RUN, TM_EXPIRED} tm_state_t;
//   also localparam MS_PER_S = 1000.
//  Sub-module ms_tick_gen #(DIV): prescaler with clear_in, en_in, tick_out.
//   Reused by elapsed counter and future info/nps reporting.
//  One registered multiply stage (CALC); no other pipelining.
// TESTING  (bench uses CLOCK_FREQ=4000 -> CYC_PER_MS=4)
//  time=8000, inc=500, go -> time_out=2000 at go+2.
//   Decrements 1/cycle; expired_out pulse at go+2002.
//   elapsed_ms_out=500 at expiry; EXPIRED held until move_valid.
//  time=16, inc=9000, go -> budget 2ms -> time_out=8; fixed_en=1, fixed_ms=0 -> clamped 1ms -> time_out=4.
//  fixed_ms=32'hFFFF_FFFF -> time_out saturates 32'hFFFF_FFFF.
//   abort at go+10 -> time_out=0, expired pulse at go+11.
//  RUN with move_valid on the cycle time_out==1 -> IDLE, no expired_out, running_out=0.
//  go during RUN at time_out=37 with time=800, inc=40 -> time_out=160 two cycles later, elapsed_ms_out=0.
//  rst_in=0 mid-RUN -> next cycle time_out=0, running_out=0, elapsed_ms_out=0, no pulse.
//   go_in held 1 during reset is ignored.

Source files
------------

// File: rtl/chess_pkg.sv
// Shared types and constants for the chess engine control blocks.
// Holds the search time manager state encoding and small arithmetic helpers.
package chess_pkg;

   typedef enum logic [1:0] {
      TM_IDLE,
      TM_CALC,
      TM_RUN,
      TM_EXPIRED
   } tm_state_t;

   localparam int unsigned MS_PER_S = 1000;

   function automatic logic [31:0] sat_u32(input logic [63:0] v);
      return (v[63:32] != 32'd0) ? 32'hFFFF_FFFF : v[31:0];
   endfunction

   function automatic logic [31:0] min_u32(input logic [31:0] a,
                                           input logic [31:0] b);
      return (a < b) ? a : b;
   endfunction

   function automatic logic [31:0] max_u32(input logic [31:0] a,
                                           input logic [31:0] b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/search_time_manager_ms_tick_gen.sv
// Millisecond prescaler: counts 0..DIV-1 while enabled and pulses on wrap.
// Shared by the elapsed-time counter and later info/nps reporting.
module ms_tick_gen
   import chess_pkg::*;
#(
   parameter int unsigned DIV = 4
) (
   input  logic clk_in,
   input  logic rst_in,
   input  logic clear_in,
   input  logic en_in,
   output logic tick_out
);

   localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;
   logic         wrap;

   assign wrap     = en_in && !clear_in && (cnt_q == LAST);
   assign tick_out = wrap;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_in) begin
         cnt_d = '0;
      end else if (en_in) begin
         cnt_d = wrap ? '0 : cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/search_time_manager.sv
// Converts UCI clock info into a per-move cycle budget and counts it down.
// Also reports elapsed search time in ms and pulses expiry once per search.
module search_time_manager
   import chess_pkg::*;
#(
   parameter int unsigned CLOCK_FREQ    = 40_000_000,
   parameter int unsigned TIME_SHIFT    = 3,
   parameter int unsigned MIN_BUDGET_MS = 1
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        go_in,
   input  logic [31:0] time_ms_in,
   input  logic [31:0] inc_ms_in,
   input  logic        fixed_en_in,
   input  logic [31:0] fixed_ms_in,
   input  logic        abort_in,
   input  logic        move_valid_in,
   output logic [31:0] time_out,
   output logic        running_out,
   output logic        expired_out,
   output logic [31:0] elapsed_ms_out
);

   localparam int unsigned CYC_PER_MS = CLOCK_FREQ / MS_PER_S;
   localparam logic [63:0] CYC64 = 64'(CYC_PER_MS);
   localparam logic [31:0] MIN_MS = 32'(MIN_BUDGET_MS);

   tm_state_t   state_q;
   tm_state_t   state_d;
   logic [31:0] time_q;
   logic [31:0] time_d;
   logic [31:0] budget_q;
   logic [31:0] budget_d;
   logic [31:0] elapsed_q;
   logic [31:0] elapsed_d;
   logic        expired_q;
   logic        expired_d;
   logic        running_q;
   logic        running_d;

   logic [31:0] frac_ms;
   logic [31:0] auto_ms;
   logic [31:0] sel_ms;
   logic [63:0] product;
   logic [31:0] load_cyc;
   logic        ms_tick;
   logic        tick_en;

   // Budget selection is combinational off the inputs; only latched on go.
   always_comb begin
      frac_ms = time_ms_in >> TIME_SHIFT;
      auto_ms = min_u32(inc_ms_in, frac_ms);
      sel_ms  = fixed_en_in ? fixed_ms_in : auto_ms;
      budget_d = budget_q;
      if (go_in) begin
         budget_d = max_u32(sel_ms, MIN_MS);
      end
   end

   assign product  = {32'd0, budget_q} * CYC64;
   assign load_cyc = sat_u32(product);

   assign tick_en = (state_q != TM_IDLE);

   ms_tick_gen #(
      .DIV(CYC_PER_MS)
   ) u_tick (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .clear_in(go_in),
      .en_in   (tick_en),
      .tick_out(ms_tick)
   );

   always_comb begin
      elapsed_d = elapsed_q;
      if (go_in) begin
         elapsed_d = '0;
      end else if (ms_tick && (elapsed_q != 32'hFFFF_FFFF)) begin
         elapsed_d = elapsed_q + 32'd1;
      end
   end

   // go > move_valid > abort > natural expiry
   always_comb begin
      state_d   = state_q;
      time_d    = time_q;
      expired_d = 1'b0;
      if (go_in) begin
         state_d = TM_CALC;
         time_d  = '0;
      end else begin
         unique case (state_q)
            TM_IDLE: begin
               time_d = '0;
            end
            TM_CALC: begin
               if (move_valid_in) begin
                  state_d = TM_IDLE;
                  time_d  = '0;
               end else if (abort_in) begin
                  state_d   = TM_EXPIRED;
                  time_d    = '0;
                  expired_d = 1'b1;
               end else begin
                  state_d = TM_RUN;
                  time_d  = load_cyc;
               end
            end
            TM_RUN: begin
               if (move_valid_in) begin
                  state_d = TM_IDLE;
                  time_d  = '0;
               end else if (abort_in || (time_q <= 32'd1)) begin
                  state_d   = TM_EXPIRED;
                  time_d    = '0;
                  expired_d = 1'b1;
               end else begin
                  time_d = time_q - 32'd1;
               end
            end
            TM_EXPIRED: begin
               time_d = '0;
               if (move_valid_in) begin
                  state_d = TM_IDLE;
               end
            end
            default: begin
               state_d = TM_IDLE;
               time_d  = '0;
            end
         endcase
      end
      running_d = (state_d == TM_CALC) || (state_d == TM_RUN);
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state_q   <= TM_IDLE;
         time_q    <= '0;
         budget_q  <= '0;
         elapsed_q <= '0;
         expired_q <= 1'b0;
         running_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         time_q    <= time_d;
         budget_q  <= budget_d;
         elapsed_q <= elapsed_d;
         expired_q <= expired_d;
         running_q <= running_d;
      end
   end

   assign time_out       = time_q;
   assign running_out    = running_q;
   assign expired_out    = expired_q;
   assign elapsed_ms_out = elapsed_q;

endmodule

// File: tb/tb_search_time_manager.sv
// Self-checking bench for search_time_manager at 4 cycles per ms.
// Expected values come from the budget rules evaluated with plain arithmetic.
module tb_search_time_manager;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        go;
   logic [31:0] time_ms;
   logic [31:0] inc_ms;
   logic        fixed_en;
   logic [31:0] fixed_ms;
   logic        abort;
   logic        mv;
   logic [31:0] time_out;
   logic        running;
   logic        expired;
   logic [31:0] elapsed;

   int passed = 0;
   int total  = 0;
   int edges  = 0;
   int go_edge = 0;
   int exp_cnt = 0;

   search_time_manager #(
      .CLOCK_FREQ   (4000),
      .TIME_SHIFT   (3),
      .MIN_BUDGET_MS(1)
   ) dut (
      .clk_in        (clk),
      .rst_in        (rst_n),
      .go_in         (go),
      .time_ms_in    (time_ms),
      .inc_ms_in     (inc_ms),
      .fixed_en_in   (fixed_en),
      .fixed_ms_in   (fixed_ms),
      .abort_in      (abort),
      .move_valid_in (mv),
      .time_out      (time_out),
      .running_out   (running),
      .expired_out   (expired),
      .elapsed_ms_out(elapsed)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (expired === 1'b1) exp_cnt++;

   initial begin
      #50ms;
      $display("FAIL watchdog: sim time limit reached, got timeout want completion");
      $fatal(1);
   end

   // Budget in cycles from remaining time, increment and fixed override.
   function automatic logic [31:0] model_cycles(input logic [31:0] t,
                                                input logic [31:0] i,
                                                input logic fe,
                                                input logic [31:0] fm);
      longint unsigned b, p;
      if (fe) b = fm;
      else b = (i < (t >> 3)) ? i : (t >> 3);
      if (b < 1) b = 1;
      p = b * 4;
      if (p > 64'hFFFF_FFFF) return 32'hFFFF_FFFF;
      return p[31:0];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      edges++;
   endtask

   task automatic do_go(input logic [31:0] t, input logic [31:0] i,
                        input logic fe, input logic [31:0] fm);
      time_ms  = t;
      inc_ms   = i;
      fixed_en = fe;
      fixed_ms = fm;
      go = 1'b1;
      step();
      go_edge = edges;
      go = 1'b0;
      time_ms  = $urandom;
      inc_ms   = $urandom;
      fixed_en = $urandom_range(0, 1);
      fixed_ms = $urandom;
   endtask

   task automatic move_done();
      mv = 1'b1;
      step();
      mv = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      go = 1'b1;
      time_ms = 8000; inc_ms = 500; fixed_en = 0; fixed_ms = 0;
      abort = 0; mv = 0;
      step();
      step();
      total++;
      if (time_out !== 0 || running !== 0 || expired !== 0 || elapsed !== 0)
         $display("FAIL reset_outputs: got t=%0d r=%0b e=%0b el=%0d want all 0",
                  time_out, running, expired, elapsed);
      else passed++;
      rst_n = 1'b1;
      go = 1'b0;
      step();
      step();
      total++;
      if (running !== 0 || time_out !== 0)
         $display("FAIL reset_idle: got r=%0b t=%0d want 0 0", running, time_out);
      else passed++;
   endtask

   task automatic test_basic();
      int e0;
      e0 = exp_cnt;
      do_go(8000, 500, 1'b0, 32'd0);
      step();
      total++;
      if (time_out !== 2000 || running !== 1)
         $display("FAIL basic_load: got t=%0d r=%0b want 2000 1", time_out, running);
      else passed++;
      repeat (1999) step();
      total++;
      if (time_out !== 1 || expired !== 0)
         $display("FAIL basic_last: got t=%0d e=%0b want 1 0", time_out, expired);
      else passed++;
      step();
      total++;
      if (time_out !== 0 || expired !== 1 || elapsed !== 500)
         $display("FAIL basic_expiry: got t=%0d e=%0b el=%0d want 0 1 500",
                  time_out, expired, elapsed);
      else passed++;
      abort = 1'b1;
      step();
      abort = 1'b0;
      repeat (5) step();
      total++;
      if (expired !== 0 || running !== 0 || time_out !== 0 || exp_cnt !== e0 + 1)
         $display("FAIL basic_hold: got e=%0b r=%0b t=%0d pulses=%0d want 0 0 0 %0d",
                  expired, running, time_out, exp_cnt - e0, 1);
      else passed++;
      move_done();
      total++;
      if (running !== 0 || elapsed !== (edges - go_edge) / 4)
         $display("FAIL basic_idle: got r=%0b el=%0d want 0 %0d",
                  running, elapsed, (edges - go_edge) / 4);
      else passed++;
   endtask

   task automatic test_budget();
      logic [31:0] tt [4];
      logic [31:0] ii [4];
      logic        ff [4];
      logic [31:0] mm [4];
      logic [31:0] want [4];
      tt = '{16, 100, 5, 0};
      ii = '{9000, 7, 5, 0};
      ff = '{0, 1, 1, 0};
      mm = '{0, 0, 5, 0};
      want = '{8, 4, 20, 4};
      for (int k = 0; k < 4; k++) begin
         do_go(tt[k], ii[k], ff[k], mm[k]);
         step();
         total++;
         if (time_out !== want[k])
            $display("FAIL budget_%0d: got %0d want %0d", k, time_out, want[k]);
         else passed++;
         move_done();
      end
   endtask

   task automatic test_saturate_abort();
      int e0;
      e0 = exp_cnt;
      do_go(8000, 500, 1'b1, 32'hFFFF_FFFF);
      step();
      total++;
      if (time_out !== 32'hFFFF_FFFF)
         $display("FAIL sat_load: got %h want ffffffff", time_out);
      else passed++;
      repeat (8) step();
      total++;
      if (time_out !== 32'hFFFF_FFF7)
         $display("FAIL sat_count: got %h want fffffff7", time_out);
      else passed++;
      abort = 1'b1;
      step();
      abort = 1'b0;
      total++;
      if (time_out !== 0 || expired !== 1 || running !== 0)
         $display("FAIL abort_expiry: got t=%0d e=%0b r=%0b want 0 1 0",
                  time_out, expired, running);
      else passed++;
      step();
      step();
      total++;
      if (expired !== 0 || exp_cnt !== e0 + 1)
         $display("FAIL abort_once: got e=%0b pulses=%0d want 0 1",
                  expired, exp_cnt - e0);
      else passed++;
      move_done();
   endtask

   task automatic test_move_on_last();
      int e0;
      e0 = exp_cnt;
      do_go(0, 0, 1'b1, 32'd1);
      step();
      repeat (3) step();
      total++;
      if (time_out !== 1)
         $display("FAIL mv_last_pre: got %0d want 1", time_out);
      else passed++;
      move_done();
      step();
      total++;
      if (time_out !== 0 || running !== 0 || expired !== 0 || exp_cnt !== e0)
         $display("FAIL mv_last: got t=%0d r=%0b e=%0b pulses=%0d want 0 0 0 0",
                  time_out, running, expired, exp_cnt - e0);
      else passed++;
   endtask

   task automatic test_restart();
      int e0;
      do_go(8000, 500, 1'b0, 32'd0);
      step();
      repeat (1963) step();
      total++;
      if (time_out !== 37)
         $display("FAIL restart_pre: got %0d want 37", time_out);
      else passed++;
      e0 = exp_cnt;
      do_go(800, 40, 1'b0, 32'd0);
      step();
      total++;
      if (time_out !== 160 || elapsed !== 0 || running !== 1 || exp_cnt !== e0)
         $display("FAIL restart: got t=%0d el=%0d r=%0b pulses=%0d want 160 0 1 0",
                  time_out, elapsed, running, exp_cnt - e0);
      else passed++;
      move_done();
   endtask

   task automatic test_reset_mid_run();
      int e0;
      do_go(8000, 500, 1'b0, 32'd0);
      repeat (50) step();
      e0 = exp_cnt;
      rst_n = 1'b0;
      go = 1'b1;
      step();
      total++;
      if (time_out !== 0 || running !== 0 || elapsed !== 0 || expired !== 0)
         $display("FAIL rst_mid: got t=%0d r=%0b el=%0d e=%0b want 0 0 0 0",
                  time_out, running, elapsed, expired);
      else passed++;
      step();
      rst_n = 1'b1;
      go = 1'b0;
      step();
      step();
      total++;
      if (running !== 0 || time_out !== 0 || exp_cnt !== e0)
         $display("FAIL rst_go_ignored: got r=%0b t=%0d pulses=%0d want 0 0 0",
                  running, time_out, exp_cnt - e0);
      else passed++;
   endtask

   task automatic test_random();
      logic [31:0] t, i, fm, e;
      logic        fe;
      int act, k, e0, el;
      for (int it = 0; it < 30; it++) begin
         t  = $urandom_range(0, 400);
         i  = $urandom_range(0, 100);
         fe = ($urandom_range(0, 3) == 0);
         fm = $urandom_range(0, 20);
         e  = model_cycles(t, i, fe, fm);
         do_go(t, i, fe, fm);
         step();
         total++;
         if (time_out !== e || elapsed !== 0 || running !== 1)
            $display("FAIL rnd_load_%0d: got t=%0d el=%0d r=%0b want %0d 0 1",
                     it, time_out, elapsed, running, e);
         else passed++;
         act = $urandom_range(0, 3);
         if (it == 29 && act == 3) act = 2;
         e0 = exp_cnt;
         case (act)
            0: begin
               repeat (e - 1) step();
               total++;
               if (time_out !== 1 || expired !== 0)
                  $display("FAIL rnd_last_%0d: got t=%0d e=%0b want 1 0",
                           it, time_out, expired);
               else passed++;
               step();
               total++;
               if (time_out !== 0 || expired !== 1 ||
                   elapsed !== (edges - go_edge) / 4)
                  $display("FAIL rnd_exp_%0d: got t=%0d e=%0b el=%0d want 0 1 %0d",
                           it, time_out, expired, elapsed, (edges - go_edge) / 4);
               else passed++;
               step();
               total++;
               if (expired !== 0 || running !== 0 || exp_cnt !== e0 + 1)
                  $display("FAIL rnd_held_%0d: got e=%0b r=%0b pulses=%0d want 0 0 1",
                           it, expired, running, exp_cnt - e0);
               else passed++;
               move_done();
            end
            1: begin
               k = $urandom_range(0, e - 2);
               repeat (k) step();
               total++;
               if (time_out !== e - k)
                  $display("FAIL rnd_cnt_%0d: got %0d want %0d", it, time_out, e - k);
               else passed++;
               abort = 1'b1;
               step();
               abort = 1'b0;
               total++;
               if (time_out !== 0 || expired !== 1 || running !== 0)
                  $display("FAIL rnd_abort_%0d: got t=%0d e=%0b r=%0b want 0 1 0",
                           it, time_out, expired, running);
               else passed++;
               move_done();
            end
            2: begin
               k = $urandom_range(0, e - 1);
               repeat (k) step();
               move_done();
               el = (edges - go_edge) / 4;
               step();
               step();
               total++;
               if (time_out !== 0 || running !== 0 || expired !== 0 ||
                   elapsed !== el || exp_cnt !== e0)
                  $display("FAIL rnd_mv_%0d: got t=%0d r=%0b e=%0b el=%0d p=%0d want 0 0 0 %0d 0",
                           it, time_out, running, expired, elapsed, exp_cnt - e0, el);
               else passed++;
            end
            default: begin
               k = $urandom_range(0, e - 2);
               repeat (k) step();
            end
         endcase
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_budget();
      test_saturate_abort();
      test_move_on_last();
      test_restart();
      test_reset_mid_run();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
